writeback_unit: RTL and testbench

//  MIPS writeback stage: the write side of the register file read by the decode stage.

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/load_align.sv | 54 +++++
 rtl/writeback_unit.sv | 167 ++++++++++++++++
 tb/tb_writeback_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// MIPS shared definitions: opcodes, writeback
// state encoding and classification helpers.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_write_t;

  function automatic logic is_load(
    input logic [5:0] op
  );
    return (op == OP_LB)  ||
           (op == OP_LH)  ||
           (op == OP_LW)  ||
           (op == OP_LBU) ||
           (op == OP_LHU);
  endfunction

  // ALU immediates 0x08..0x0F, lui included
  function automatic logic writes_rt(
    input logic [5:0] op
  );
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/load_align.sv
// Big-endian lane select and extension
// for load data; flags misaligned accesses.
module load_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] value,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // byte/half lane pick, addr 0 is the MSB lane
  always_comb begin
    lane_b = word[31:24];
    unique case (addr)
      2'd0: lane_b = word[31:24];
      2'd1: lane_b = word[23:16];
      2'd2: lane_b = word[15:8];
      2'd3: lane_b = word[7:0];
    endcase
    lane_h = addr[1] ? word[15:0]
                     : word[31:16];
  end

  // extension per load type
  always_comb begin
    value    = word;
    misalign = 1'b0;
    unique case (1'b1)
      (opcode == OP_LB):
        value = {{24{lane_b[7]}}, lane_b};
      (opcode == OP_LBU):
        value = {24'd0, lane_b};
      (opcode == OP_LH): begin
        value    = {{16{lane_h[15]}}, lane_h};
        misalign = addr[0];
      end
      (opcode == OP_LHU): begin
        value    = {16'd0, lane_h};
        misalign = addr[0];
      end
      (opcode == OP_LW): begin
        value    = word;
        misalign = |addr;
      end
      default: value = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// MIPS writeback stage: classifies retired
// instructions, waits for loads, writes RF.
module writeback_unit
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [5:0]  ex_opcode,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_alu_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_regwrite,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        err_spurious
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       ld_op_q, ld_op_d;
  logic [1:0]       ld_addr_q, ld_addr_d;
  logic [4:0]       ld_rt_q, ld_rt_d;
  wb_write_t        wr_q, wr_d;
  logic             mis_q, mis_d;
  logic             to_q, to_d;
  logic             sp_q, sp_d;

  logic             idle;
  logic [5:0]       al_op;
  logic [1:0]       al_addr;
  logic [31:0]      al_value;
  logic             al_misalign;

  assign idle = (state_q == ST_IDLE);

  // IDLE checks the incoming load for
  // alignment; WAIT_MEM aligns the captured one
  assign al_op   = idle ? ex_opcode
                        : ld_op_q;
  assign al_addr = idle ? ex_alu_result[1:0]
                        : ld_addr_q;

  load_align u_align (
    .opcode   (al_op),
    .addr     (al_addr),
    .word     (mem_rdata),
    .value    (al_value),
    .misalign (al_misalign)
  );

  // state, counter, capture and output regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ld_op_q   <= '0;
      ld_addr_q <= '0;
      ld_rt_q   <= '0;
      wr_q      <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
      sp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_op_q   <= ld_op_d;
      ld_addr_q <= ld_addr_d;
      ld_rt_q   <= ld_rt_d;
      wr_q      <= wr_d;
      mis_q     <= mis_d;
      to_q      <= to_d;
      sp_q      <= sp_d;
    end
  end

  // next state, write request and error flags
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_op_d   = ld_op_q;
    ld_addr_d = ld_addr_q;
    ld_rt_d   = ld_rt_q;
    wr_d      = wr_q;
    wr_d.en   = 1'b0;
    mis_d     = mis_q;
    to_d      = to_q;
    sp_d      = sp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_rvalid) sp_d = 1'b1;
        if (ex_valid) begin
          unique case (1'b1)
            is_load(ex_opcode): begin
              if (al_misalign) begin
                mis_d = 1'b1;
              end else begin
                state_d   = ST_WAIT_MEM;
                cnt_d     = '0;
                ld_op_d   = ex_opcode;
                ld_addr_d = ex_alu_result[1:0];
                ld_rt_d   = ex_rt;
              end
            end
            (ex_opcode == OP_RTYPE): begin
              if (ex_rd != 5'd0) begin
                wr_d.en   = 1'b1;
                wr_d.dst  = ex_rd;
                wr_d.data = ex_alu_result;
              end
            end
            writes_rt(ex_opcode): begin
              if (ex_rt != 5'd0) begin
                wr_d.en   = 1'b1;
                wr_d.dst  = ex_rt;
                wr_d.data = ex_alu_result;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (ld_rt_q != 5'd0) begin
            wr_d.en   = 1'b1;
            wr_d.dst  = ld_rt_q;
            wr_d.data = al_value;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ex_ready      = idle;
  assign rf_regwrite   = wr_q.en;
  assign rf_write_reg  = wr_q.dst;
  assign rf_write_data = wr_q.data;
  assign fwd_valid     = wr_q.en;
  assign fwd_reg       = wr_q.dst;
  assign fwd_data      = wr_q.data;
  assign err_misalign  = mis_q;
  assign err_timeout   = to_q;
  assign err_spurious  = sp_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized and directed bench for the
// writeback unit against a behavioural model.
module tb_writeback_unit;

  localparam int MT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_opcode;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_regwrite;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        err_misalign;
  logic        err_timeout;
  logic        err_spurious;

  int n_checks = 0;
  int n_errs   = 0;

  logic exp_mis, exp_to, exp_sp;

  logic [5:0] ops [19] = '{
    6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C,
    6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
    6'h23, 6'h24, 6'h25, 6'h2B, 6'h28,
    6'h04, 6'h05, 6'h02, 6'h3F
  };

  writeback_unit #(
    .MEM_TIMEOUT (MT),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_opcode     (ex_opcode),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_alu_result (ex_alu_result),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rf_regwrite   (rf_regwrite),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data),
    .err_misalign  (err_misalign),
    .err_timeout   (err_timeout),
    .err_spurious  (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_ld(
    input logic [5:0] op
  );
    return op == 6'h20 || op == 6'h21 ||
           op == 6'h23 || op == 6'h24 ||
           op == 6'h25;
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [5:0]  op,
    input int          a,
    input logic [31:0] w
  );
    logic [31:0] b, h;
    b = (w >> (8 * (3 - a))) & 32'hFF;
    h = (w >> (16 * (1 - a / 2))) & 32'hFFFF;
    case (op)
      6'h20: return b >= 128 ? b - 256 : b;
      6'h24: return b;
      6'h21: return h >= 32768 ? h - 65536 : h;
      6'h25: return h;
      default: return w;
    endcase
  endfunction

  task automatic check_errs(input string tag);
    check({tag, "_mis"}, err_misalign, exp_mis);
    check({tag, "_to"}, err_timeout, exp_to);
    check({tag, "_sp"}, err_spurious, exp_sp);
  endtask

  task automatic check_write(
    input string       tag,
    input logic        en,
    input logic [4:0]  dst,
    input logic [31:0] data
  );
    check({tag, "_we"}, rf_regwrite, en);
    check({tag, "_fv"}, fwd_valid, en);
    if (en) begin
      check({tag, "_reg"}, rf_write_reg, dst);
      check({tag, "_dat"}, rf_write_data, data);
      check({tag, "_freg"}, fwd_reg, dst);
      check({tag, "_fdat"}, fwd_data, data);
    end
  endtask

  // delay: WAIT_MEM cycle carrying rvalid,
  // 0 means data never arrives
  task automatic do_instr(
    input string       tag,
    input logic [5:0]  op,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [31:0] alu,
    input int          delay,
    input logic [31:0] word
  );
    int  a;
    int  lo;
    logic mis, wr;
    logic [4:0] dst;
    a = int'(alu % 4);
    check({tag, "_rdy0"}, ex_ready, 1);
    ex_valid      = 1'b1;
    ex_opcode     = op;
    ex_rt         = rt;
    ex_rd         = rd;
    ex_alu_result = alu;
    step();
    ex_valid = 1'b0;
    if (!is_ld(op)) begin
      wr  = op == 6'h00 ||
            (op >= 6'h08 && op <= 6'h0F);
      dst = op == 6'h00 ? rd : rt;
      check_write(tag, wr && dst != 0, dst, alu);
      step();
      check({tag, "_end"}, rf_regwrite, 0);
    end else begin
      mis = (op == 6'h23 && a != 0) ||
            ((op == 6'h21 || op == 6'h25) &&
             a % 2 != 0);
      if (mis) begin
        exp_mis = 1'b1;
        check({tag, "_mwe"}, rf_regwrite, 0);
        check({tag, "_mrdy"}, ex_ready, 1);
      end else begin
        lo = 0;
        for (int k = 1; k <= MT; k++) begin
          if (ex_ready == 1'b0) lo++;
          check({tag, "_wwe"}, rf_regwrite, 0);
          if (k == delay) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word;
            step();
            mem_rvalid = 1'b0;
            break;
          end
          step();
        end
        check({tag, "_lo"}, lo,
              delay == 0 ? MT : delay);
        if (delay != 0) begin
          check_write(tag, rt != 0, rt,
                      ref_load(op, a, word));
        end else begin
          exp_to = 1'b1;
          check({tag, "_twe"}, rf_regwrite, 0);
        end
        check({tag, "_rdy1"}, ex_ready, 1);
        step();
        check({tag, "_end"}, rf_regwrite, 0);
      end
    end
    check_errs(tag);
  endtask

  task automatic stray_rvalid(input string tag);
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    step();
    mem_rvalid = 1'b0;
    exp_sp = 1'b1;
    check({tag, "_we"}, rf_regwrite, 0);
    check_errs(tag);
  endtask

  initial begin
    logic [5:0]  op;
    logic [4:0]  rt, rd;
    logic [31:0] alu;
    int          dly;
    rst_n         = 1'b0;
    ex_valid      = 1'b0;
    ex_opcode     = '0;
    ex_rt         = '0;
    ex_rd         = '0;
    ex_alu_result = '0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    exp_mis = 1'b0;
    exp_to  = 1'b0;
    exp_sp  = 1'b0;
    step();
    step();
    check("rst_rdy", ex_ready, 1);
    check("rst_we", rf_regwrite, 0);
    check("rst_reg", rf_write_reg, 0);
    check("rst_dat", rf_write_data, 0);
    check("rst_fv", fwd_valid, 0);
    check("rst_fdat", fwd_data, 0);
    check_errs("rst");
    rst_n = 1'b1;
    step();

    do_instr("add", 6'h00, 5'd9, 5'd5,
             32'h1234, 0, 0);
    check("add_val", rf_write_data, 32'h1234);
    do_instr("sw", 6'h2B, 5'd4, 5'd0,
             32'h100, 0, 0);
    do_instr("beq", 6'h04, 5'd4, 5'd2,
             32'h0, 0, 0);
    do_instr("lb", 6'h20, 5'd3, 5'd0,
             32'h1001, 4, 32'h11F23344);
    do_instr("lhu", 6'h25, 5'd7, 5'd0,
             32'h1002, 2, 32'hAAAA8001);
    do_instr("lh", 6'h21, 5'd7, 5'd0,
             32'h1002, 3, 32'hAAAA8001);
    do_instr("lw", 6'h23, 5'd8, 5'd0,
             32'h1000, 1, 32'hCAFEF00D);
    do_instr("lwedge", 6'h23, 5'd8, 5'd0,
             32'h1000, MT, 32'h0BADBEEF);
    do_instr("ori0", 6'h0D, 5'd0, 5'd6,
             32'h55, 0, 0);
    do_instr("lw0", 6'h23, 5'd0, 5'd0,
             32'h1000, 2, 32'h12345678);
    do_instr("lwmis", 6'h23, 5'd8, 5'd0,
             32'h1002, 1, 0);
    do_instr("lwto", 6'h23, 5'd9, 5'd0,
             32'h2000, 0, 0);
    stray_rvalid("spur");

    // back-to-back non-load writes
    for (int i = 0; i < 8; i++) begin
      op  = ops[$urandom_range(0, 7)];
      rt  = 5'($urandom_range(1, 31));
      rd  = 5'($urandom_range(1, 31));
      alu = $urandom;
      ex_valid      = 1'b1;
      ex_opcode     = op;
      ex_rt         = rt;
      ex_rd         = rd;
      ex_alu_result = alu;
      step();
      check_write("b2b", 1'b1,
                  op == 6'h00 ? rd : rt, alu);
    end
    ex_valid = 1'b0;
    step();
    check("b2b_end", rf_regwrite, 0);

    // reset in the middle of a load
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_mis = 1'b0;
    exp_to  = 1'b0;
    exp_sp  = 1'b0;
    step();
    check_errs("clr");
    ex_valid      = 1'b1;
    ex_opcode     = 6'h23;
    ex_rt         = 5'd4;
    ex_alu_result = 32'h40;
    step();
    ex_valid = 1'b0;
    check("mid_rdy", ex_ready, 0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_rdy", ex_ready, 1);
    check("mrst_we", rf_regwrite, 0);
    step();
    rst_n = 1'b1;
    step();
    stray_rvalid("late");

    // randomized instruction stream
    for (int i = 0; i < 80; i++) begin
      op  = ops[$urandom_range(0, 18)];
      rt  = 5'($urandom_range(0, 31));
      rd  = 5'($urandom_range(0, 31));
      alu = $urandom;
      dly = $urandom_range(0, MT);
      if ($urandom_range(0, 9) == 0)
        stray_rvalid("rspur");
      do_instr("rnd", op, rt, rd, alu,
               dly, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
